// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier: classify/unpack, multiply, normalise/round/pack.
// A single global advance enable stalls every stage when the output is held by the consumer.
module fp_mul_pipe #(
    parameter int EXP_WIDTH  = 8,
    parameter int SIG_WIDTH  = 7,
    parameter int FLAG_WIDTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [EXP_WIDTH+SIG_WIDTH:0]   i_data_a,
    input  logic [EXP_WIDTH+SIG_WIDTH:0]   i_data_b,
    input  logic                           i_rnd_mode,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [EXP_WIDTH+SIG_WIDTH:0]   o_data,
    output logic [FLAG_WIDTH-1:0]          o_flag
);

    localparam int W    = EXP_WIDTH + SIG_WIDTH + 1;
    localparam int PW   = 2 * SIG_WIDTH + 2;
    localparam int XW   = EXP_WIDTH + 2;
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;

    localparam logic [EXP_WIDTH-1:0]  EXP_ONES = '1;
    localparam logic [SIG_WIDTH-1:0]  SIG_QNAN = {1'b1, {(SIG_WIDTH-1){1'b0}}};
    localparam logic signed [XW-1:0]  BIAS_X   = XW'(BIAS);
    localparam logic signed [XW-1:0]  MIN_X    = XW'(1 - BIAS);

    localparam logic [FLAG_WIDTH-1:0] FL_NAN  = FLAG_WIDTH'(8);
    localparam logic [FLAG_WIDTH-1:0] FL_ZERO = FLAG_WIDTH'(4);
    localparam logic [FLAG_WIDTH-1:0] FL_INF  = FLAG_WIDTH'(2);
    localparam logic [FLAG_WIDTH-1:0] FL_NORM = FLAG_WIDTH'(1);

    logic w_en;

    // stage 1 registers
    logic                    r1_valid;
    logic                    r1_sign;
    logic                    r1_spec;
    logic [W-1:0]            r1_spec_data;
    logic [FLAG_WIDTH-1:0]   r1_spec_flag;
    logic [EXP_WIDTH-1:0]    r1_exp_a;
    logic [EXP_WIDTH-1:0]    r1_exp_b;
    logic [SIG_WIDTH:0]      r1_man_a;
    logic [SIG_WIDTH:0]      r1_man_b;
    logic                    r1_rnd;

    // stage 2 registers
    logic                    r2_valid;
    logic                    r2_sign;
    logic                    r2_spec;
    logic [W-1:0]            r2_spec_data;
    logic [FLAG_WIDTH-1:0]   r2_spec_flag;
    logic signed [XW-1:0]    r2_exp;
    logic [PW-1:0]           r2_prod;
    logic                    r2_rnd;

    // stage 3 (output) registers
    logic                    r3_valid;
    logic [W-1:0]            r3_data;
    logic [FLAG_WIDTH-1:0]   r3_flag;

    assign w_en    = !r3_valid || i_ready;
    assign o_ready = w_en;
    assign o_valid = r3_valid;
    assign o_data  = r3_data;
    assign o_flag  = r3_flag;

    // ---------------- S1: classify / unpack ----------------
    logic                  w_sa, w_sb, w_sign;
    logic [EXP_WIDTH-1:0]  w_ea, w_eb;
    logic [SIG_WIDTH-1:0]  w_fa, w_fb;
    logic                  w_a_zero, w_a_inf, w_a_nan;
    logic                  w_b_zero, w_b_inf, w_b_nan;
    logic                  w_spec;
    logic [W-1:0]          w_spec_data;
    logic [FLAG_WIDTH-1:0] w_spec_flag;

    assign {w_sa, w_ea, w_fa} = i_data_a;
    assign {w_sb, w_eb, w_fb} = i_data_b;
    assign w_sign   = w_sa ^ w_sb;

    assign w_a_zero = (w_ea == '0);
    assign w_a_inf  = (w_ea == EXP_ONES) && (w_fa == '0);
    assign w_a_nan  = (w_ea == EXP_ONES) && (w_fa != '0);
    assign w_b_zero = (w_eb == '0);
    assign w_b_inf  = (w_eb == EXP_ONES) && (w_fb == '0);
    assign w_b_nan  = (w_eb == EXP_ONES) && (w_fb != '0);

    always_comb begin
        w_spec      = 1'b1;
        w_spec_data = '0;
        w_spec_flag = FL_ZERO;
        if (w_a_nan || w_b_nan) begin
            w_spec_data = {1'b0, EXP_ONES, SIG_QNAN};
            w_spec_flag = FL_NAN;
        end else if ((w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
            w_spec_data = {1'b1, EXP_ONES, SIG_QNAN};
            w_spec_flag = FL_NAN;
        end else if (w_a_zero || w_b_zero) begin
            // subnormal operands land here too: they are flushed to signed zero
            w_spec_data = {w_sign, {(W-1){1'b0}}};
            w_spec_flag = FL_ZERO;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_data = {w_sign, EXP_ONES, {SIG_WIDTH{1'b0}}};
            w_spec_flag = FL_INF;
        end else begin
            w_spec = 1'b0;
        end
    end

    // ---------------- S2: significand multiply + exponent add ----------------
    logic [PW-1:0]        w_prod;
    logic signed [XW-1:0] w_exp_sum;

    assign w_prod    = PW'(r1_man_a) * PW'(r1_man_b);
    assign w_exp_sum = XW'(r1_exp_a) + XW'(r1_exp_b) - XW'(2 * BIAS);

    // ---------------- S3: normalise / round / pack ----------------
    logic                  w_msb;
    logic [PW-2:0]         w_norm;
    logic [SIG_WIDTH-1:0]  w_frac;
    logic                  w_guard, w_sticky, w_inc;
    logic [SIG_WIDTH:0]    w_frac_r;
    logic signed [XW-1:0]  w_exp_r;
    logic [EXP_WIDTH-1:0]  w_exp_biased;
    logic [W-1:0]          w_res_data;
    logic [FLAG_WIDTH-1:0] w_res_flag;

    // w_norm drops the leading one, so its top SIG_WIDTH bits are the kept fraction
    assign w_msb    = r2_prod[PW-1];
    assign w_norm   = w_msb ? r2_prod[PW-2:0] : {r2_prod[PW-3:0], 1'b0};
    assign w_frac   = w_norm[PW-2 -: SIG_WIDTH];
    assign w_guard  = w_norm[SIG_WIDTH];
    assign w_sticky = |w_norm[SIG_WIDTH-1:0];
    assign w_inc    = r2_rnd && w_guard && (w_sticky || w_frac[0]);
    assign w_frac_r = {1'b0, w_frac} + (SIG_WIDTH+1)'(w_inc);
    // a rounding carry leaves the fraction all-zero, so only the exponent moves
    assign w_exp_r  = r2_exp + XW'(w_msb) + XW'(w_frac_r[SIG_WIDTH]);
    assign w_exp_biased = EXP_WIDTH'(w_exp_r + BIAS_X);

    always_comb begin
        w_res_data = '0;
        w_res_flag = FL_ZERO;
        if (r2_spec) begin
            w_res_data = r2_spec_data;
            w_res_flag = r2_spec_flag;
        end else if (w_exp_r > BIAS_X) begin
            w_res_data = {r2_sign, EXP_ONES, {SIG_WIDTH{1'b0}}};
            w_res_flag = FL_INF;
        end else if (w_exp_r < MIN_X) begin
            w_res_data = {r2_sign, {(W-1){1'b0}}};
            w_res_flag = FL_ZERO;
        end else begin
            w_res_data = {r2_sign, w_exp_biased, w_frac_r[SIG_WIDTH-1:0]};
            w_res_flag = FL_NORM;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r3_valid <= 1'b0;
            r3_data  <= '0;
            r3_flag  <= '0;
        end else if (w_en) begin
            r1_valid     <= i_valid;
            r1_sign      <= w_sign;
            r1_spec      <= w_spec;
            r1_spec_data <= w_spec_data;
            r1_spec_flag <= w_spec_flag;
            r1_exp_a     <= w_ea;
            r1_exp_b     <= w_eb;
            r1_man_a     <= {1'b1, w_fa};
            r1_man_b     <= {1'b1, w_fb};
            r1_rnd       <= i_rnd_mode;

            r2_valid     <= r1_valid;
            r2_sign      <= r1_sign;
            r2_spec      <= r1_spec;
            r2_spec_data <= r1_spec_data;
            r2_spec_flag <= r1_spec_flag;
            r2_exp       <= w_exp_sum;
            r2_prod      <= w_prod;
            r2_rnd       <= r1_rnd;

            r3_valid     <= r2_valid;
            if (r2_valid) begin
                r3_data <= w_res_data;
                r3_flag <= w_res_flag;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: bf16 directed table, reset/backpressure sequences,
// and randomized bf16/fp16 streams scored against an integer-arithmetic reference model.
module tb_fp_mul_pipe;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    // bf16 instance (default parameters)
    logic        bf_i_valid, bf_o_ready, bf_i_mode, bf_o_valid, bf_i_ready;
    logic [15:0] bf_i_a, bf_i_b, bf_o_data;
    logic [3:0]  bf_o_flag;

    // fp16 instance
    logic        hf_i_valid, hf_o_ready, hf_i_mode, hf_o_valid, hf_i_ready;
    logic [15:0] hf_i_a, hf_i_b, hf_o_data;
    logic [3:0]  hf_o_flag;

    fp_mul_pipe dut_bf (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(bf_i_valid), .o_ready(bf_o_ready),
        .i_data_a(bf_i_a), .i_data_b(bf_i_b), .i_rnd_mode(bf_i_mode),
        .o_valid(bf_o_valid), .i_ready(bf_i_ready), .o_data(bf_o_data), .o_flag(bf_o_flag)
    );

    fp_mul_pipe #(.EXP_WIDTH(5), .SIG_WIDTH(10), .FLAG_WIDTH(4)) dut_hf (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(hf_i_valid), .o_ready(hf_o_ready),
        .i_data_a(hf_i_a), .i_data_b(hf_i_b), .i_rnd_mode(hf_i_mode),
        .o_valid(hf_o_valid), .i_ready(hf_i_ready), .o_data(hf_o_data), .o_flag(hf_o_flag)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Reference: exact integer product, explicit remainder-based rounding. Returns {flag, data}.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic mode, input int ew, input int sw);
        longint bias, emax, ea, eb, fa, fb, sa, sb, sgn, qnan, p, l, sh, q, rem, half, e;
        logic [31:0] d;
        logic [3:0]  f;
        bias = (64'd1 << (ew - 1)) - 1;
        emax = (64'd1 << ew) - 1;
        ea = (a >> sw) & emax;
        eb = (b >> sw) & emax;
        fa = a & ((64'd1 << sw) - 1);
        fb = b & ((64'd1 << sw) - 1);
        sa = (a >> (ew + sw)) & 1;
        sb = (b >> (ew + sw)) & 1;
        sgn = sa ^ sb;
        qnan = 64'd1 << (sw - 1);
        if ((ea == emax && fa != 0) || (eb == emax && fb != 0)) begin
            d = 32'((emax << sw) | qnan); f = 4'b1000;
        end else if ((ea == 0 && eb == emax) || (ea == emax && eb == 0)) begin
            d = 32'((64'd1 << (ew + sw)) | (emax << sw) | qnan); f = 4'b1000;
        end else if (ea == 0 || eb == 0) begin
            d = 32'(sgn << (ew + sw)); f = 4'b0100;
        end else if (ea == emax || eb == emax) begin
            d = 32'((sgn << (ew + sw)) | (emax << sw)); f = 4'b0010;
        end else begin
            p = (fa + (64'd1 << sw)) * (fb + (64'd1 << sw));
            l = (p >= (64'd1 << (2 * sw + 1))) ? 2 * sw + 1 : 2 * sw;
            sh = l - sw;
            q = p >> sh;
            rem = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (mode && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
            if (q == (64'd1 << (sw + 1))) begin
                q = q / 2;
                l = l + 1;
            end
            e = (ea - bias) + (eb - bias) + (l - 2 * sw);
            if (e > bias) begin
                d = 32'((sgn << (ew + sw)) | (emax << sw)); f = 4'b0010;
            end else if (e < 1 - bias) begin
                d = 32'(sgn << (ew + sw)); f = 4'b0100;
            end else begin
                d = 32'((sgn << (ew + sw)) | ((e + bias) << sw) | (q - (64'd1 << sw))); f = 4'b0001;
            end
        end
        return {f, d};
    endfunction

    function automatic logic [15:0] rand_op(input int ew, input int sw);
        logic [31:0] r;
        int bias, e;
        r = $urandom;
        bias = (1 << (ew - 1)) - 1;
        if ($urandom_range(0, 1) == 1) begin
            e = bias - 4 + int'($urandom_range(0, 8));
            return 16'((32'(r[31]) << (ew + sw)) | (32'(e) << sw) | (r & ((32'd1 << sw) - 1)));
        end
        return r[15:0];
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [15:0] d;
        logic [3:0]  f;
    } vec_t;

    vec_t vt[14];

    // Random bf16 stream scored against the model; optional 5-cycle output stall mid-stream.
    task automatic stream_bf(input int npairs, input bit hold_mid);
        logic [35:0] sb[$];
        logic [35:0] e;
        logic [15:0] a, b, held_d;
        logic [3:0]  held_f;
        logic        m, rdy, stall;
        int sent, got, cyc, extra;
        sent = 0; got = 0; cyc = 0; extra = 0;
        a = rand_op(8, 7); b = rand_op(8, 7); m = 1'($urandom_range(0, 1));
        held_d = '0; held_f = '0;
        while (got < npairs && cyc < npairs * 20 + 50) begin
            stall = hold_mid && cyc >= 5 && cyc < 10;
            rdy = hold_mid ? !stall : ($urandom_range(0, 3) != 0);
            bf_i_ready = rdy;
            bf_i_valid = (sent < npairs) && (hold_mid || $urandom_range(0, 3) != 0);
            bf_i_a = a; bf_i_b = b; bf_i_mode = m;
            #1;
            chk("o_ready_rule", 32'(bf_o_ready), 32'(!bf_o_valid || rdy));
            if (stall) begin
                chk("stall_o_ready", 32'(bf_o_ready), 0);
                chk("stall_o_valid", 32'(bf_o_valid), 1);
                if (cyc == 5) begin
                    held_d = bf_o_data;
                    held_f = bf_o_flag;
                end else begin
                    chk("stall_data_stable", 32'(bf_o_data), 32'(held_d));
                    chk("stall_flag_stable", 32'(bf_o_flag), 32'(held_f));
                end
            end
            if (bf_o_valid && rdy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(bf_o_data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("bf_stream_data", 32'(bf_o_data), e[31:0]);
                    chk("bf_stream_flag", 32'(bf_o_flag), 32'(e[35:32]));
                    got++;
                end
            end
            if (bf_i_valid && bf_o_ready) begin
                sb.push_back(ref_mul(32'(a), 32'(b), m, 8, 7));
                sent++;
                a = rand_op(8, 7); b = rand_op(8, 7); m = 1'($urandom_range(0, 1));
            end
            step();
            cyc++;
        end
        bf_i_valid = 1'b0;
        bf_i_ready = 1'b1;
        chk("bf_stream_count", 32'(got), 32'(npairs));
        chk("bf_stream_leftover", 32'(sb.size()), 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bf_o_valid) extra++;
            step();
        end
        chk("bf_stream_no_extra", 32'(extra), 0);
    endtask

    task automatic stream_hf(input int npairs);
        logic [35:0] sb[$];
        logic [35:0] e;
        logic [15:0] a, b;
        logic        m, rdy;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        a = rand_op(5, 10); b = rand_op(5, 10); m = 1'($urandom_range(0, 1));
        while (got < npairs && cyc < npairs * 3 + 50) begin
            rdy = ($urandom_range(0, 15) != 0);
            hf_i_ready = rdy;
            hf_i_valid = (sent < npairs);
            hf_i_a = a; hf_i_b = b; hf_i_mode = m;
            #1;
            if (hf_o_valid && rdy) begin
                if (sb.size() == 0) begin
                    chk("hf_unexpected_result", 32'(hf_o_data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("hf_data", 32'(hf_o_data), e[31:0]);
                    chk("hf_flag", 32'(hf_o_flag), 32'(e[35:32]));
                    got++;
                end
            end
            if (hf_i_valid && hf_o_ready) begin
                sb.push_back(ref_mul(32'(a), 32'(b), m, 5, 10));
                sent++;
                a = rand_op(5, 10); b = rand_op(5, 10); m = 1'($urandom_range(0, 1));
            end
            step();
            cyc++;
        end
        hf_i_valid = 1'b0;
        chk("hf_count", 32'(got), 32'(npairs));
        chk("hf_leftover", 32'(sb.size()), 0);
    endtask

    // Issue one bf16 pair and wait (bounded) for its result; checks latency, data, flag.
    task automatic single_bf(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic m, input logic [15:0] d, input logic [3:0] f);
        int lat;
        bf_i_ready = 1'b1;
        bf_i_valid = 1'b1; bf_i_a = a; bf_i_b = b; bf_i_mode = m;
        step();
        bf_i_valid = 1'b0;
        bf_i_mode = ~m;
        lat = 1;
        while (!bf_o_valid && lat < 8) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 3);
        chk({tag, "_data"}, 32'(bf_o_data), 32'(d));
        chk({tag, "_flag"}, 32'(bf_o_flag), 32'(f));
        step();
        chk({tag, "_single_shot"}, 32'(bf_o_valid), 0);
    endtask

    initial begin
        int stale;
        vt[0]  = '{16'h3FC0, 16'h4000, 1'b0, 16'h4040, 4'b0001};
        vt[1]  = '{16'h3F81, 16'h3FC0, 1'b0, 16'h3FC1, 4'b0001};
        vt[2]  = '{16'h3F81, 16'h3FC0, 1'b1, 16'h3FC2, 4'b0001};
        vt[3]  = '{16'h3FC1, 16'h3FC1, 1'b0, 16'h4011, 4'b0001};
        vt[4]  = '{16'h3FC1, 16'h3FC1, 1'b1, 16'h4012, 4'b0001};
        vt[5]  = '{16'h0000, 16'h7F80, 1'b0, 16'hFFC0, 4'b1000};
        vt[6]  = '{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 4'b1000};
        vt[7]  = '{16'h7F00, 16'h4000, 1'b0, 16'h7F80, 4'b0010};
        vt[8]  = '{16'h0080, 16'h0080, 1'b0, 16'h0000, 4'b0100};
        vt[9]  = '{16'h8001, 16'h3F80, 1'b0, 16'h8000, 4'b0100};
        vt[10] = '{16'hBFC0, 16'h4000, 1'b1, 16'hC040, 4'b0001};
        vt[11] = '{16'h7F80, 16'hC000, 1'b0, 16'hFF80, 4'b0010};
        vt[12] = '{16'h3F80, 16'h3F80, 1'b1, 16'h3F80, 4'b0001};
        vt[13] = '{16'h3F80, 16'h7F80, 1'b0, 16'h7F80, 4'b0010};

        i_rst = 1'b1;
        bf_i_valid = 1'b1; bf_i_a = 16'h3FC0; bf_i_b = 16'h4000; bf_i_mode = 1'b0; bf_i_ready = 1'b1;
        hf_i_valid = 1'b0; hf_i_a = '0; hf_i_b = '0; hf_i_mode = 1'b0; hf_i_ready = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        bf_i_valid = 1'b0;
        chk("reset_o_valid", 32'(bf_o_valid), 0);
        chk("reset_o_data", 32'(bf_o_data), 0);
        chk("reset_o_flag", 32'(bf_o_flag), 0);
        chk("reset_o_ready", 32'(bf_o_ready), 1);
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bf_o_valid) stale++;
        end
        chk("reset_drops_operands", 32'(stale), 0);

        for (int i = 0; i < 14; i++)
            single_bf($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].m, vt[i].d, vt[i].f);

        // Reset with three operands in flight and a fourth presented during reset.
        bf_i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bf_i_valid = 1'b1; bf_i_a = 16'h3FC0; bf_i_b = 16'h3FC0; bf_i_mode = 1'b0;
            step();
        end
        i_rst = 1'b1;
        bf_i_a = 16'h4000;
        step();
        i_rst = 1'b0;
        bf_i_valid = 1'b0;
        chk("midrst_o_valid", 32'(bf_o_valid), 0);
        chk("midrst_o_data", 32'(bf_o_data), 0);
        chk("midrst_o_flag", 32'(bf_o_flag), 0);
        chk("midrst_o_ready", 32'(bf_o_ready), 1);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bf_o_valid) stale++;
        end
        chk("midrst_no_stale", 32'(stale), 0);
        single_bf("post_reset", 16'h3FC0, 16'h4000, 1'b0, 16'h4040, 4'b0001);

        stream_bf(8, 1'b1);
        stream_bf(400, 1'b0);
        stream_hf(10000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
